// File: rtl/imm_decode_ctrl.sv
// Decode-stage sequencer for the external immediate extender: classifies the opcode, drives CEU/Dint,
// waits EXT_LAT cycles, captures Dout and hands {instr, imm, type} downstream. Optional macro: IMM_PERF_CNT_EN.
module imm_decode_ctrl #(
    parameter int unsigned EXT_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic [2:0]  CEU,
    output logic [24:0] Dint,
    input  logic [31:0] Dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_imm,
    output logic [2:0]  out_type,
    output logic        illegal
`ifdef IMM_PERF_CNT_EN
    ,
    output logic [15:0] cnt_instr,
    output logic [15:0] cnt_illegal
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_HOLD
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXT_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] dec_ceu;

    always_comb begin
        dec_ceu = 3'd7;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_ceu = 3'd0;
            7'b0100011:                                     dec_ceu = 3'd1;
            7'b1100011:                                     dec_ceu = 3'd2;
            7'b0110111, 7'b0010111:                         dec_ceu = 3'd3;
            7'b1101111:                                     dec_ceu = 3'd4;
            7'b0110011:                                     dec_ceu = 3'd5;
            default:                                        dec_ceu = 3'd7;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            CEU       <= 3'd7;
            Dint      <= '0;
            out_instr <= '0;
            out_imm   <= '0;
            out_type  <= 3'd7;
            illegal   <= 1'b0;
            cnt       <= '0;
        end else if (flush) begin
            // Abort wins over both a pending handshake and a new accept.
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            CEU       <= 3'd7;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        CEU       <= dec_ceu;
                        Dint      <= in_instr[31:7];
                        out_instr <= in_instr;
                        cnt       <= CNT_INIT;
                        in_ready  <= 1'b0;
                        state     <= S_EXT;
                    end
                end
                S_EXT: begin
                    if (cnt == '0) begin
                        out_imm   <= (CEU >= 3'd5) ? '0 : Dout;
                        out_type  <= CEU;
                        illegal   <= (CEU == 3'd7);
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMM_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_instr   <= '0;
            cnt_illegal <= '0;
        end else if (!flush && state == S_HOLD && out_valid && out_ready) begin
            if (cnt_instr != '1)
                cnt_instr <= cnt_instr + 1'b1;
            if (illegal && cnt_illegal != '1)
                cnt_illegal <= cnt_illegal + 1'b1;
        end
    end
`endif

endmodule
